sync_fifo_ctrl: RTL and testbench

- Pointer, flag and handshake controller for the dual-port synchronous RAM, which has active-low rd/wr, a registered read address and a combinational data_B.
- Turns user-side active-high write/read requests into RAM strobes and addresses.
- Tracks occupancy and produces full/empty/watermark flags, plus a read-data-valid strobe aligned to RAM data_B.
- Instantiated next to the RAM inside the synchronous FIFO top; the data path (data_A/data_B) bypasses this block.

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/fifo_ptr.sv | 32 +++
 rtl/sync_fifo_ctrl.sv | 115 +++++++++++
 tb/tb_sync_fifo_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared widths, depth helper and default watermark thresholds for the
// synchronous FIFO controller.
package sync_fifo_pkg;

    localparam int L_DEF = 5;
    localparam int W_DEF = 8;

    function automatic int DEPTH(input int l);
        return 1 << l;
    endfunction

    localparam int AF_TH_DEF = DEPTH(L_DEF) - 2;
    localparam int AE_TH_DEF = 2;

endpackage

// File: rtl/fifo_ptr.sv
// (L+1)-bit wrapping FIFO pointer with increment enable and a synchronous,
// active-low clear. The extra MSB distinguishes full from empty.
module fifo_ptr #(
    parameter int L = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    output logic [L:0] ptr_o
);

    logic [L:0] ptr_q;
    logic [L:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Pointer, flag and handshake controller for a dual-port synchronous FIFO RAM.
// Build option: define FIFO_ERR_FLAG_EN to get sticky overflow/underflow flags.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int L     = L_DEF,
    parameter int AF_TH = AF_TH_DEF,
    parameter int AE_TH = AE_TH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic         rd_en,
    output logic         mem_wr_n,
    output logic [L-1:0] mem_waddr,
    output logic         mem_rd_n,
    output logic [L-1:0] mem_raddr,
    output logic         rd_valid,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [L:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam logic [L:0] AF_TH_C = AF_TH[L:0];
    localparam logic [L:0] AE_TH_C = AE_TH[L:0];

    logic [L:0] wptr;
    logic [L:0] rptr;
    logic       wr_acc;
    logic       rd_acc;
    logic [L:0] count_q;
    logic [L:0] count_d;
    logic       rd_valid_q;

    // Full and empty come from registered pointers only, so the accept
    // decision has no combinational path from the request inputs.
    assign full   = (wptr[L] != rptr[L]) && (wptr[L-1:0] == rptr[L-1:0]);
    assign empty  = (wptr == rptr);
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    fifo_ptr #(.L(L)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (wr_acc),
        .ptr_o (wptr)
    );

    fifo_ptr #(.L(L)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (rd_acc),
        .ptr_o (rptr)
    );

    // Strobes are held inactive during reset so the RAM sees no stray access.
    assign mem_wr_n  = !(wr_acc && rst_n);
    assign mem_rd_n  = !(rd_acc && rst_n);
    assign mem_waddr = wptr[L-1:0];
    assign mem_raddr = rptr[L-1:0];

    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_valid_q <= rd_acc;
        end
    end

    assign count        = count_q;
    assign rd_valid     = rd_valid_q;
    assign almost_full  = (count_q >= AF_TH_C);
    assign almost_empty = (count_q <= AE_TH_C);

`ifdef FIFO_ERR_FLAG_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed, table-driven bench for sync_fifo_ctrl with a small behavioural
// model of the dual-port RAM (registered read address, combinational data_B).
module tb_sync_fifo_ctrl;

`ifdef FIFO_ERR_FLAG_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic       rd_en;
    logic       mem_wr_n;
    logic [4:0] mem_waddr;
    logic       mem_rd_n;
    logic [4:0] mem_raddr;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [5:0] count;
    logic       overflow;
    logic       underflow;

    logic [7:0] data_A;
    logic [7:0] data_B;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.L(5), .AF_TH(30), .AE_TH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .mem_wr_n     (mem_wr_n),
        .mem_waddr    (mem_waddr),
        .mem_rd_n     (mem_rd_n),
        .mem_raddr    (mem_raddr),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // RAM model: strobes are snapshotted mid-cycle so the posedge write/read
    // uses the pre-edge controller outputs without any scheduling race.
    logic [7:0] ram [32];
    logic       wr_n_s = 1'b1;
    logic       rd_n_s = 1'b1;
    logic [4:0] waddr_s = '0;
    logic [4:0] raddr_s = '0;
    logic [7:0] da_s = '0;
    logic [4:0] raddr_q = '0;

    always @(negedge clk) begin
        wr_n_s  = mem_wr_n;
        rd_n_s  = mem_rd_n;
        waddr_s = mem_waddr;
        raddr_s = mem_raddr;
        da_s    = data_A;
    end

    always @(posedge clk) begin
        if (!wr_n_s) ram[waddr_s] <= da_s;
        if (!rd_n_s) raddr_q <= raddr_s;
    end

    assign data_B = ram[raddr_q];

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic       rst_n;
        logic       wr;
        logic       rd;
        logic [5:0] cnt;
        logic       empty;
        logic       full;
        logic       ae;
        logic       af;
        logic       wr_n;
        logic       rd_n;
        logic       rv;
        logic       uf;
        logic [4:0] wa;
        logic [4:0] ra;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];
    vec_t obs;
    vec_t exp_v;

    initial begin
        rst_n  = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        data_A = 8'h00;

        //           rst wr rd cnt emp ful ae af wrn rdn rv uf wa ra
        vecs[0]  = '{1'b1,1'b0,1'b0,6'd0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,5'd0,5'd0};
        vecs[1]  = '{1'b1,1'b0,1'b1,6'd0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,5'd0,5'd0};
        vecs[2]  = '{1'b1,1'b1,1'b1,6'd0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,5'd0,5'd0};
        vecs[3]  = '{1'b1,1'b0,1'b0,6'd1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,5'd1,5'd0};
        vecs[4]  = '{1'b1,1'b1,1'b0,6'd1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,5'd1,5'd0};
        vecs[5]  = '{1'b1,1'b1,1'b0,6'd2,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,5'd2,5'd0};
        vecs[6]  = '{1'b1,1'b0,1'b0,6'd3,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,5'd3,5'd0};
        vecs[7]  = '{1'b1,1'b1,1'b1,6'd3,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'd3,5'd0};
        vecs[8]  = '{1'b1,1'b0,1'b1,6'd3,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,5'd4,5'd1};
        vecs[9]  = '{1'b1,1'b0,1'b1,6'd2,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,5'd4,5'd2};
        vecs[10] = '{1'b1,1'b0,1'b1,6'd1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,5'd4,5'd3};
        vecs[11] = '{1'b1,1'b0,1'b0,6'd0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,5'd4,5'd4};
        vecs[12] = '{1'b1,1'b0,1'b0,6'd0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,5'd4,5'd4};
        vecs[13] = '{1'b0,1'b1,1'b1,6'd0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,5'd4,5'd4};
        vecs[14] = '{1'b1,1'b0,1'b0,6'd0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,5'd0,5'd0};

        do_reset();

        // Table-driven vectors: outputs observed mid-cycle with inputs applied.
        for (int i = 0; i < NV; i++) begin
            rst_n  = vecs[i].rst_n;
            wr_en  = vecs[i].wr;
            rd_en  = vecs[i].rd;
            data_A = 8'(i);
            #1;
            exp_v    = vecs[i];
            exp_v.uf = vecs[i].uf & ERR_EN;
            obs = '{rst_n, wr_en, rd_en, count, empty, full, almost_empty, almost_full,
                    mem_wr_n, mem_rd_n, rd_valid, underflow, mem_waddr, mem_raddr};
            $display("vec %0d rst_n=%0b wr=%0b rd=%0b count=%0d wr_n=%0b rd_n=%0b rv=%0b",
                     i, rst_n, wr_en, rd_en, count, mem_wr_n, mem_rd_n, rd_valid);
            chk($sformatf("vec%0d", i), 32'(obs), 32'(exp_v));
            tick();
        end

        // 32 back-to-back writes, then a rejected 33rd.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            wr_en  = 1'b1;
            data_A = 8'(i);
            #1;
            $display("fill %0d waddr=%0d count=%0d af=%0b", i, mem_waddr, count, almost_full);
            chk($sformatf("fill_waddr%0d", i), 32'(mem_waddr), 32'(i));
            chk($sformatf("fill_wr_n%0d", i), 32'(mem_wr_n), 32'd0);
            chk($sformatf("fill_af%0d", i), 32'(almost_full), 32'(i >= 30));
            tick();
        end
        chk("full_at_32", 32'(full), 32'd1);
        chk("count_32", 32'(count), 32'd32);
        #1;
        chk("wr33_wr_n", 32'(mem_wr_n), 32'd1);
        tick();
        wr_en = 1'b0;
        $display("write33 count=%0d overflow=%0b", count, overflow);
        chk("wr33_count", 32'(count), 32'd32);
        chk("wr33_overflow", 32'(overflow), 32'(ERR_EN));

        // Full with simultaneous requests: only the read is taken.
        wr_en  = 1'b1;
        rd_en  = 1'b1;
        data_A = 8'hEE;
        #1;
        chk("fullrw_wr_n", 32'(mem_wr_n), 32'd1);
        chk("fullrw_rd_n", 32'(mem_rd_n), 32'd0);
        chk("fullrw_raddr", 32'(mem_raddr), 32'd0);
        tick();
        wr_en = 1'b0;
        $display("fullrw count=%0d full=%0b rv=%0b dB=%0h", count, full, rd_valid, data_B);
        chk("fullrw_count", 32'(count), 32'd31);
        chk("fullrw_full", 32'(full), 32'd0);
        chk("fullrw_rv", 32'(rd_valid), 32'd1);
        chk("fullrw_data", 32'(data_B), 32'd0);
        for (int j = 1; j < 32; j++) begin
            rd_en = 1'b1;
            tick();
            chk($sformatf("drain_data%0d", j), 32'(data_B), 32'(j));
            chk($sformatf("drain_rv%0d", j), 32'(rd_valid), 32'd1);
        end
        rd_en = 1'b0;
        chk("drained_empty", 32'(empty), 32'd1);
        chk("drained_count", 32'(count), 32'd0);

        // Single write of 0xA5 then a read.
        do_reset();
        wr_en  = 1'b1;
        data_A = 8'hA5;
        #1;
        chk("a5_waddr", 32'(mem_waddr), 32'd0);
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        #1;
        chk("a5_raddr", 32'(mem_raddr), 32'd0);
        chk("a5_rd_n", 32'(mem_rd_n), 32'd0);
        tick();
        rd_en = 1'b0;
        $display("a5 read rv=%0b dB=%0h empty=%0b", rd_valid, data_B, empty);
        chk("a5_rv", 32'(rd_valid), 32'd1);
        chk("a5_data", 32'(data_B), 32'hA5);
        chk("a5_empty", 32'(empty), 32'd1);
        tick();
        chk("a5_rv_drop", 32'(rd_valid), 32'd0);

        // Streaming through the pointer wrap, then reset mid-stream.
        do_reset();
        wr_en  = 1'b1;
        data_A = 8'h10;
        tick();
        for (int k = 0; k < 40; k++) begin
            wr_en  = 1'b1;
            rd_en  = 1'b1;
            data_A = 8'(8'h11 + k);
            tick();
            $display("stream %0d dB=%0h rv=%0b count=%0d", k, data_B, rd_valid, count);
            chk($sformatf("stream_data%0d", k), 32'(data_B), 32'(8'h10 + k));
            chk($sformatf("stream_rv%0d", k), 32'(rd_valid), 32'd1);
        end
        chk("stream_count", 32'(count), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_wr_n", 32'(mem_wr_n), 32'd1);
        chk("rst_rd_n", 32'(mem_rd_n), 32'd1);
        tick();
        $display("midreset count=%0d rv=%0b wa=%0d ra=%0d", count, rd_valid, mem_waddr, mem_raddr);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rv", 32'(rd_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_waddr", 32'(mem_waddr), 32'd0);
        chk("rst_raddr", 32'(mem_raddr), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
